guess_entry_ctrl: RTL
=====================

// Module: guess_entry_ctrl
// PURPOSE
//   Sequences player keypad entry for Bulls and Cows. Takes the ten one-hot digit buttons
//   plus DEL/ENTER, debounces them and encodes each press to 4-bit BCD. Assembles a guess
//   of NUM_DIGITS distinct digits and offers it downstream (scorer) via valid/ready.
//   Sits between the keypad inputs (already synchronised to clk) and the scoring logic.
// PARAMETERS
//   NUM_DIGITS       4   digits per guess (1..8)
//   DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a key (>=1)
// PORTS
//   clk          in   1              system clock, all logic on rising edge
//   rst          in   1              synchronous, active-high reset
//   key          in   10             digit buttons, key[n] = digit n
//   del_key      in   1              backspace button
//   enter_key    in   1              submit button
//   guess_out    out  4*NUM_DIGITS   BCD guess, first-entered digit in MS nibble
//   digit_count  out  4              digits currently held (0..NUM_DIGITS)
//   guess_valid  out  1              complete guess offered
//   guess_ready  in   1              consumer accepts guess when valid&ready
//   dup_err      out  1              1-cycle pulse: rejected duplicate digit
//   full         out  1              buffer holds NUM_DIGITS digits (state FULL or OFFER)
// BEHAVIOUR
//   Key qualification (12 inputs: key[9:0], del_key, enter_key):
//   - Pattern valid only if exactly one of the 12 is high; 0 or >=2 high clears debounce count.
//   - Debounce counter increments each cycle the same single key is high; a different single
//     key restarts the count at 1 for that key.
//   - On the DEBOUNCE_CYCLES-th consecutive sample the press is accepted (one-cycle internal
//     strobe); effect visible on outputs at the next edge. Key high from cycle 0 -> visible
//     at cycle DEBOUNCE_CYCLES.
//   - After acceptance, armed=0; re-arms only after a cycle with all 12 inputs low.
//     A held key is accepted exactly once.
//   FSM: ENTRY -> FULL -> OFFER -> ENTRY.
//   - ENTRY: digit d accepted: if d already in positions [0..count-1] -> dup_err=1 for one
//     cycle, no change; else nibble[count]=d, count+1; if count becomes NUM_DIGITS -> FULL.
//     DEL: if count>0, count-1 and that nibble cleared to 0; at count 0 no effect.
//     ENTER ignored.
//   - FULL: digit keys ignored (no dup_err). DEL -> remove last digit, back to ENTRY.
//     ENTER -> OFFER.
//   - OFFER: guess_valid=1; guess_out held stable. All key acceptances ignored; armed
//     tracking continues. On valid&ready edge: buffer cleared to 0, count=0, guess_valid=0,
//     state ENTRY, all visible the next cycle.
//   - guess_out reflects the live buffer in every state; unfilled nibbles are 0 and are
//     qualified by digit_count.
//   Reset (sync): state ENTRY, guess_out=0, digit_count=0, guess_valid=0, dup_err=0, full=0,
//   debounce count=0, armed=1. Reset overrides any state, including OFFER mid-handshake.
//   A key held through reset is counted from zero after reset deasserts.
// TESTING (bench uses DEBOUNCE_CYCLES=4, NUM_DIGITS=4)
//   1. Press 1,2,3,4 (each high 6 cycles, low 2) -> digit_count 1..4, guess_out=16'h1234,
//      full=1. ENTER -> guess_valid=1. ready low 5 cycles -> output stable.
//      ready=1 -> next cycle valid=0, count=0, guess_out=0.
//   2. Press 5 then 5 -> one-cycle dup_err on second press, count stays 1,
//      guess_out=16'h5000.
//   3. key[7] high 3 cycles, low 1, high 3 -> no acceptance. key[2]&key[3] high 10 cycles
//      -> no acceptance. key[4]&enter_key high -> ignored.
//   4. key[9] 50 cycles, release, key[8] held 50 cycles -> exactly two acceptances.
//      DEL -> count 1, guess_out=16'h9000.
//   5. ENTER at count 3 -> no effect. Fill to 4, DEL in FULL -> ENTRY with count 3.
//      Digit key in FULL -> ignored, no dup_err.
//   6. Digit keys during OFFER -> buffer unchanged. Assert rst mid-OFFER -> next cycle
//      valid=0, count=0, full=0.

Source files
------------

// File: rtl/guess_entry_if.sv
// Keypad-to-scorer bundle for the Bulls and Cows guess entry controller.
// The controller drives the master side; the scorer/keypad environment drives the slave side.
interface guess_entry_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [9:0]              key;
    logic                    del_key;
    logic                    enter_key;
    logic [4*NUM_DIGITS-1:0] guess_out;
    logic [3:0]              digit_count;
    logic                    guess_valid;
    logic                    guess_ready;
    logic                    dup_err;
    logic                    full;
    logic [1:0]              state_dbg;

    // Handshake: guess_valid stays high and guess_out stays stable until a clock edge
    // where guess_valid & guess_ready are both high; that edge is the single transfer.
    // valid never depends combinationally on ready.
    modport master (
        input  key, del_key, enter_key, guess_ready,
        output guess_out, digit_count, guess_valid, dup_err, full, state_dbg
    );

    modport slave (
        output key, del_key, enter_key, guess_ready,
        input  guess_out, digit_count, guess_valid, dup_err, full, state_dbg
    );
endinterface

// File: rtl/guess_entry_ctrl.sv
// Debounces keypad presses, assembles a guess of distinct BCD digits and offers it
// to the scorer over a valid/ready handshake.
module guess_entry_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic         clk,
    input logic         rst,
    guess_entry_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_FULL  = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    // ---------------- key qualification ----------------
    logic [11:0]   keys_vec;
    logic [11:0]   last_vec;
    logic          single;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_cnt_next;
    logic          armed;
    logic          accept;

    assign keys_vec = {bus.enter_key, bus.del_key, bus.key};
    assign single   = $onehot(keys_vec);

    // Count saturates at DEBOUNCE_CYCLES; armed prevents a held key from re-firing.
    always_comb begin
        db_cnt_next = '0;
        if (single) begin
            if (keys_vec == last_vec && db_cnt != '0) begin
                if (db_cnt == CW'(DEBOUNCE_CYCLES)) begin
                    db_cnt_next = db_cnt;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end else begin
                db_cnt_next = CW'(1);
            end
        end
    end

    assign accept = armed && single && (db_cnt_next == CW'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            last_vec <= '0;
            armed    <= 1'b1;
        end else begin
            db_cnt   <= db_cnt_next;
            last_vec <= keys_vec;
            if (accept) begin
                armed <= 1'b0;
            end else if (keys_vec == 12'd0) begin
                armed <= 1'b1;
            end
        end
    end

    // ---------------- accepted key decode ----------------
    logic [3:0] key_digit;
    logic       is_digit;
    logic       is_del;
    logic       is_enter;

    always_comb begin
        key_digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.key[i]) begin
                key_digit = 4'(i);
            end
        end
    end

    assign is_digit = accept && (bus.key != 10'd0);
    assign is_del   = accept && bus.del_key;
    assign is_enter = accept && bus.enter_key;

    // ---------------- guess buffer and FSM ----------------
    // Index 0 is the first-entered digit, which lands in the MS nibble when flattened.
    logic [0:NUM_DIGITS-1][3:0] digits;
    logic [0:NUM_DIGITS-1][3:0] digits_n;
    logic [3:0]                 count;
    logic [3:0]                 count_n;
    logic [3:0]                 count_inc;
    logic [3:0]                 count_dec;
    logic                       dup_q;
    logic                       dup_n;
    logic                       is_dup;
    state_t                     state;
    state_t                     state_n;

    assign count_inc = count + 4'd1;
    assign count_dec = count - 4'd1;

    // Unfilled nibbles are zero, so only positions below count may match (digit 0 is legal).
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((4'(i) < count) && (digits[i] == key_digit)) begin
                is_dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        digits_n = digits;
        count_n  = count;
        dup_n    = 1'b0;
        case (state)
            ST_ENTRY: begin
                if (is_digit) begin
                    if (is_dup) begin
                        dup_n = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (4'(i) == count) begin
                                digits_n[i] = key_digit;
                            end
                        end
                        count_n = count_inc;
                        if (count_inc == 4'(NUM_DIGITS)) begin
                            state_n = ST_FULL;
                        end
                    end
                end else if (is_del && count != 4'd0) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (4'(i) == count_dec) begin
                            digits_n[i] = 4'd0;
                        end
                    end
                    count_n = count_dec;
                end
            end
            ST_FULL: begin
                if (is_del) begin
                    digits_n[NUM_DIGITS-1] = 4'd0;
                    count_n                = count_dec;
                    state_n                = ST_ENTRY;
                end else if (is_enter) begin
                    state_n = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus.guess_ready) begin
                    digits_n = '0;
                    count_n  = 4'd0;
                    state_n  = ST_ENTRY;
                end
            end
            default: begin
                state_n = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_ENTRY;
            digits <= '0;
            count  <= 4'd0;
            dup_q  <= 1'b0;
        end else begin
            state  <= state_n;
            digits <= digits_n;
            count  <= count_n;
            dup_q  <= dup_n;
        end
    end

    assign bus.guess_out   = digits;
    assign bus.digit_count = count;
    assign bus.guess_valid = (state == ST_OFFER);
    assign bus.full        = (state == ST_FULL) || (state == ST_OFFER);
    assign bus.dup_err     = dup_q;
    assign bus.state_dbg   = state;
endmodule
